// File: rtl/chip8_fb_scanout.sv
// CHIP-8 framebuffer scan-out: snapshots the 64x32 display and streams it as
// 256 sprite-format bytes (MSB = leftmost pixel) over a valid/ready byte stream.
module chip8_fb_scanout #(
    parameter bit AUTO_REPEAT = 1'b0,
    parameter bit INVERT      = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2047:0] display_in,
    input  logic          frame_req,
    output logic          busy,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          tx_sof,
    output logic          tx_eol,
    output logic          tx_eof,
    output logic          frame_done,
    output logic [15:0]   frame_count
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q;
    logic [7:0]      idx_q;
    logic [2047:0]   shadow_q;
    logic            pending_q;
    logic            done_q;
    logic [15:0]     count_q;

    logic            restart_d;
    logic [10:0]     base_d;
    logic [7:0]      raw_d;

    // Byte b covers row b[7:3], pixel group b[2:0]: its first pixel sits at b*8.
    function automatic logic [7:0] to_pixel_byte(input logic [7:0] raw);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = raw[i] ^ INVERT;
        end
        return r;
    endfunction

    assign restart_d = pending_q | frame_req | AUTO_REPEAT;
    assign base_d    = {idx_q, 3'b000};
    assign raw_d     = shadow_q[base_d +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 8'd0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_req || AUTO_REPEAT) begin
                        shadow_q  <= display_in;
                        idx_q     <= 8'd0;
                        pending_q <= 1'b0;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    // One-deep request memory; a restart below consumes it.
                    if (frame_req) begin
                        pending_q <= 1'b1;
                    end
                    if (tx_ready) begin
                        if (idx_q == 8'hFF) begin
                            done_q  <= 1'b1;
                            count_q <= count_q + 16'd1;
                            idx_q   <= 8'd0;
                            if (restart_d) begin
                                shadow_q  <= display_in;
                                pending_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_valid    = (state_q == STREAM);
    assign busy        = (state_q == STREAM);
    assign tx_data     = tx_valid ? to_pixel_byte(raw_d) : 8'h00;
    assign tx_sof      = tx_valid && (idx_q == 8'h00);
    assign tx_eol      = tx_valid && (idx_q[2:0] == 3'd7);
    assign tx_eof      = tx_valid && (idx_q == 8'hFF);
    assign frame_done  = done_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_chip8_fb_scanout.sv
// Bench for chip8_fb_scanout: normal and inverted instances driven in lockstep,
// every byte compared against a pixel-coordinate model of the snapshot.
module tb_chip8_fb_scanout;

    logic          clk = 1'b0;
    logic          reset;
    logic [2047:0] display_in;
    logic          frame_req;
    logic          tx_ready;

    logic          busy, tx_valid, tx_sof, tx_eol, tx_eof, frame_done;
    logic [7:0]    tx_data;
    logic [15:0]   frame_count;

    logic          i_busy, i_tx_valid, i_tx_sof, i_tx_eol, i_tx_eof, i_frame_done;
    logic [7:0]    i_tx_data;
    logic [15:0]   i_frame_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] rx [256];
    logic [7:0] rx_i [256];

    always #5 clk = ~clk;

    chip8_fb_scanout #(.AUTO_REPEAT(1'b0), .INVERT(1'b0)) dut (
        .clk(clk), .reset(reset), .display_in(display_in), .frame_req(frame_req),
        .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sof(tx_sof), .tx_eol(tx_eol), .tx_eof(tx_eof),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    chip8_fb_scanout #(.AUTO_REPEAT(1'b0), .INVERT(1'b1)) dut_inv (
        .clk(clk), .reset(reset), .display_in(display_in), .frame_req(frame_req),
        .busy(i_busy), .tx_data(i_tx_data), .tx_valid(i_tx_valid), .tx_ready(tx_ready),
        .tx_sof(i_tx_sof), .tx_eol(i_tx_eol), .tx_eof(i_tx_eof),
        .frame_done(i_frame_done), .frame_count(i_frame_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2047:0] rand_fb();
        logic [2047:0] v;
        for (int k = 0; k < 64; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: pixel (x,y) lives at snap[y*64+x]; byte b shows row b/8,
    // pixels x = (b%8)*8 .. +7 with the leftmost one in bit 7.
    function automatic logic [7:0] model_byte(input logic [2047:0] snap, input int b, input bit inv);
        logic [7:0] r;
        int y, x;
        y = b / 8;
        for (int i = 0; i < 8; i++) begin
            x = (b % 8) * 8 + i;
            r[7-i] = snap[y*64 + x] ^ inv;
        end
        return r;
    endfunction

    // Presents the current frame's bytes; req_mode 1 pulses frame_req at bytes
    // 20, 40, 255, req_mode 2 only at 255. chain = another frame must follow.
    task automatic stream_frame(input string tag, input logic [2047:0] snap, input bit stall,
                                input bit toggle, input int req_mode, input bit chain);
        int got = 0;
        int cyc = 0;
        bit was_stall = 0;
        logic [7:0] held = 8'h00;
        while (got < 256 && cyc < 4000) begin
            cyc++;
            if (toggle) display_in = rand_fb();
            tx_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            frame_req = (req_mode == 1 && (got == 20 || got == 40 || got == 255)) ||
                        (req_mode == 2 && got == 255);
            if (frame_req) tx_ready = 1'b1;
            chk({tag, "_valid"}, 16'(tx_valid), 16'd1);
            chk({tag, "_busy"}, 16'(busy), 16'd1);
            if (got > 0) chk({tag, "_done_low"}, 16'(frame_done), 16'd0);
            if (was_stall) chk({tag, "_stall_hold"}, 16'(tx_data), 16'(held));
            if (tx_ready) begin
                chk({tag, "_data"}, 16'(tx_data), 16'(model_byte(snap, got, 1'b0)));
                chk({tag, "_data_inv"}, 16'(i_tx_data), 16'(model_byte(snap, got, 1'b1)));
                chk({tag, "_sof"}, 16'(tx_sof), 16'(got == 0));
                chk({tag, "_eol"}, 16'(tx_eol), 16'(got % 8 == 7));
                chk({tag, "_eof"}, 16'(tx_eof), 16'(got == 255));
                rx[got] = tx_data;
                rx_i[got] = i_tx_data;
                got++;
                was_stall = 0;
            end else begin
                was_stall = 1;
                held = tx_data;
            end
            tick();
        end
        frame_req = 1'b0;
        tx_ready = 1'b1;
        chk({tag, "_bytes"}, 16'(got), 16'd256);
        chk({tag, "_done_pulse"}, 16'(frame_done), 16'd1);
        chk({tag, "_inv_done_pulse"}, 16'(i_frame_done), 16'd1);
        chk({tag, "_valid_after"}, 16'(tx_valid), 16'(chain));
    endtask

    task automatic start_frame(input string tag);
        frame_req = 1'b1;
        chk({tag, "_valid_before"}, 16'(tx_valid), 16'd0);
        tick();
        frame_req = 1'b0;
        chk({tag, "_valid_rise"}, 16'(tx_valid), 16'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [2047:0] snap_a, snap_b;

    initial begin
        reset = 1'b1;
        display_in = '0;
        frame_req = 1'b0;
        tx_ready = 1'b1;
        do_reset();

        chk("rst_valid", 16'(tx_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(frame_done), 16'd0);
        chk("rst_count", frame_count, 16'd0);
        chk("rst_data", 16'(tx_data), 16'd0);
        chk("rst_data_inv", 16'(i_tx_data), 16'd0);

        // Blank frame
        start_frame("blank");
        stream_frame("blank", '0, 1'b0, 1'b0, 0, 1'b0);
        chk("blank_count", frame_count, 16'd1);
        tick();
        chk("blank_done_once", 16'(frame_done), 16'd0);
        chk("blank_idle_busy", 16'(busy), 16'd0);

        // Three corner pixels, normal and inverted
        snap_a = '0;
        snap_a[0] = 1'b1;
        snap_a[1*64 + 9] = 1'b1;
        snap_a[31*64 + 63] = 1'b1;
        display_in = snap_a;
        start_frame("pix");
        stream_frame("pix", snap_a, 1'b0, 1'b0, 0, 1'b0);
        chk("pix_b0", 16'(rx[0]), 16'h80);
        chk("pix_b9", 16'(rx[9]), 16'h40);
        chk("pix_b255", 16'(rx[255]), 16'h01);
        chk("pix_b100", 16'(rx[100]), 16'h00);
        chk("pix_inv_b0", 16'(rx_i[0]), 16'h7F);
        chk("pix_inv_b9", 16'(rx_i[9]), 16'hBF);
        chk("pix_inv_b255", 16'(rx_i[255]), 16'hFE);
        chk("pix_inv_b100", 16'(rx_i[100]), 16'hFF);
        chk("pix_count", frame_count, 16'd2);

        // Random image under random backpressure
        snap_a = rand_fb();
        display_in = snap_a;
        start_frame("stall");
        stream_frame("stall", snap_a, 1'b1, 1'b0, 0, 1'b0);

        // Tear-free: display_in changes every cycle during the frame
        snap_a = rand_fb();
        display_in = snap_a;
        start_frame("tear");
        stream_frame("tear", snap_a, 1'b0, 1'b1, 0, 1'b0);
        snap_b = rand_fb();
        display_in = snap_b;
        start_frame("tear2");
        stream_frame("tear2", snap_b, 1'b1, 1'b1, 0, 1'b0);
        chk("tear_count", frame_count, 16'd5);

        // Several requests mid-frame, the last one on byte 255: one extra frame
        do_reset();
        snap_a = rand_fb();
        display_in = snap_a;
        start_frame("multi");
        stream_frame("multi", snap_a, 1'b0, 1'b0, 1, 1'b1);
        stream_frame("multi2", snap_a, 1'b0, 1'b0, 0, 1'b0);
        chk("multi_count", frame_count, 16'd2);
        tick();
        chk("multi_no_third", 16'(tx_valid), 16'd0);

        // Only a request coincident with byte 255
        snap_a = rand_fb();
        display_in = snap_a;
        start_frame("coin");
        stream_frame("coin", snap_a, 1'b0, 1'b0, 2, 1'b1);
        stream_frame("coin2", snap_a, 1'b0, 1'b0, 0, 1'b0);
        chk("coin_count", frame_count, 16'd4);

        // Reset at byte 100 with a pending request
        do_reset();
        snap_a = rand_fb();
        display_in = snap_a;
        start_frame("abort");
        for (int k = 0; k < 100; k++) begin
            tx_ready = 1'b1;
            frame_req = (k == 50);
            tick();
        end
        frame_req = 1'b0;
        chk("abort_b100", 16'(tx_data), 16'(model_byte(snap_a, 100, 1'b0)));
        reset = 1'b1;
        tick();
        chk("abort_valid", 16'(tx_valid), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_count", frame_count, 16'd0);
        chk("abort_done", 16'(frame_done), 16'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_pending", 16'(tx_valid), 16'd0);
            chk("abort_no_done", 16'(frame_done), 16'd0);
        end
        snap_b = rand_fb();
        display_in = snap_b;
        start_frame("restart");
        stream_frame("restart", snap_b, 1'b1, 1'b0, 0, 1'b0);
        chk("restart_count", frame_count, 16'd1);
        chk("restart_inv_count", i_frame_count, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
